// File: rtl/esp_cmd_port.sv
// Memory-mapped CPU responder for the ESP command link: a STATUS/DATA register pair
// in front of a 16-entry TX FIFO (CPU to link) and a 16-entry RX FIFO (link to CPU).
module esp_cmd_port #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic        bus_wren,
    input  logic        bus_rden,
    output logic [31:0] bus_rddata,
    output logic [8:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [8:0]          tx_mem [DEPTH];
    logic [7:0]          rx_mem [DEPTH];
    logic [DEPTH_LOG2:0] tx_wr_ptr, tx_rd_ptr;
    logic [DEPTH_LOG2:0] rx_wr_ptr, rx_rd_ptr;
    logic                overflow;

    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_push, rx_pop, rx_drop;
    logic ovf_clear;
    logic [31:0] status_word;
    logic unused_wrdata;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[DEPTH_LOG2] != tx_rd_ptr[DEPTH_LOG2]) &&
                      (tx_wr_ptr[DEPTH_LOG2-1:0] == tx_rd_ptr[DEPTH_LOG2-1:0]);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[DEPTH_LOG2] != rx_rd_ptr[DEPTH_LOG2]) &&
                      (rx_wr_ptr[DEPTH_LOG2-1:0] == rx_rd_ptr[DEPTH_LOG2-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign tx_pop  = !tx_empty && tx_ready;
    assign tx_push = bus_wren && bus_addr && (!tx_full || tx_pop);
    assign rx_pop  = bus_rden && bus_addr && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign rx_drop = rx_valid && rx_full && !rx_pop;

    assign ovf_clear     = bus_wren && !bus_addr && bus_wrdata[2];
    assign status_word   = {29'b0, overflow, tx_full, !rx_empty};
    assign unused_wrdata = ^bus_wrdata[31:9];

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr[DEPTH_LOG2-1:0]] <= bus_wrdata[8:0];
        if (rx_push)
            rx_mem[rx_wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            overflow   <= 1'b0;
            bus_rddata <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;

            if (rx_drop)
                overflow <= 1'b1;
            else if (ovf_clear)
                overflow <= 1'b0;

            if (bus_rden) begin
                if (!bus_addr)
                    bus_rddata <= status_word;
                else if (!rx_empty)
                    bus_rddata <= {24'b0, rx_mem[rx_rd_ptr[DEPTH_LOG2-1:0]]};
                else
                    bus_rddata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_esp_cmd_port.sv
// Bench for esp_cmd_port: directed register/FIFO scenarios plus randomized traffic,
// all checked against a queue-based model of the two FIFOs and the overflow flag.
module tb_esp_cmd_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_addr = 1'b0;
    logic [31:0] bus_wrdata = '0;
    logic        bus_wren = 1'b0;
    logic        bus_rden = 1'b0;
    logic [31:0] bus_rddata;
    logic [8:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    esp_cmd_port #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
        .bus_wren(bus_wren), .bus_rden(bus_rden), .bus_rddata(bus_rddata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    logic [8:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_rd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock: capture pre-edge inputs, advance the model, compare post-edge outputs.
    task automatic tick();
        logic        a, we, re, txr, rxv, ovf_set;
        logic [31:0] wd;
        logic [7:0]  rxd;
        a = bus_addr; we = bus_wren; re = bus_rden; wd = bus_wrdata;
        txr = tx_ready; rxv = rx_valid; rxd = rx_data;
        @(posedge clk);
        #1;
        if (re) begin
            if (!a)
                m_rd = {29'b0, m_ovf, tx_q.size() == 16, rx_q.size() != 0};
            else if (rx_q.size() != 0)
                m_rd = {24'b0, rx_q.pop_front()};
            else
                m_rd = '0;
        end
        if (txr && tx_q.size() != 0) void'(tx_q.pop_front());
        if (we && a && tx_q.size() < 16) tx_q.push_back(wd[8:0]);
        ovf_set = 1'b0;
        if (rxv) begin
            if (rx_q.size() < 16) rx_q.push_back(rxd);
            else ovf_set = 1'b1;
        end
        if (we && !a && wd[2]) m_ovf = 1'b0;
        if (ovf_set) m_ovf = 1'b1;

        check("rddata", bus_rddata, m_rd);
        check("tx_valid", {31'b0, tx_valid}, {31'b0, tx_q.size() != 0});
        if (tx_q.size() != 0) check("tx_data", {23'b0, tx_data}, {23'b0, tx_q[0]});
    endtask

    task automatic cpu_write(input logic a, input logic [31:0] d);
        bus_addr = a; bus_wrdata = d; bus_wren = 1'b1;
        tick();
        bus_wren = 1'b0;
    endtask

    task automatic cpu_read(input logic a, output logic [31:0] d);
        bus_addr = a; bus_rden = 1'b1;
        tick();
        bus_rden = 1'b0;
        d = bus_rddata;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic [8:0]  drained[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rddata", bus_rddata, 32'h0);
        check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        reset = 1'b0;

        // Post-reset register values
        cpu_read(1'b0, rd); check("init_status", rd, 32'h0);
        cpu_read(1'b1, rd); check("init_data", rd, 32'h0);

        // TX first-word fall-through and drain order
        tx_ready = 1'b0;
        cpu_write(1'b1, 32'h110);
        cpu_write(1'b1, 32'h000);
        check("tx_head_valid", {31'b0, tx_valid}, 32'h1);
        check("tx_head_data", {23'b0, tx_data}, 32'h110);
        tx_ready = 1'b1;
        tick();
        check("tx_second", {23'b0, tx_data}, 32'h000);
        tick();
        check("tx_drained", {31'b0, tx_valid}, 32'h0);

        // TX full: 17th write dropped
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cpu_write(1'b1, i);
            if (i == 15) begin
                cpu_read(1'b0, rd);
                check("tx_full_status", rd, 32'h2);
            end
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && tx_valid; i++) begin
            drained.push_back(tx_data);
            tick();
        end
        tx_ready = 1'b0;
        check("tx_drain_count", drained.size(), 32'd16);
        for (int i = 0; i < drained.size() && i < 16; i++)
            check("tx_drain_order", {23'b0, drained[i]}, i);

        // RX basic
        rx_byte(8'hA5);
        rx_byte(8'h5A);
        cpu_read(1'b0, rd); check("rx_status", rd, 32'h1);
        cpu_read(1'b1, rd); check("rx_byte0", rd, 32'hA5);
        cpu_read(1'b1, rd); check("rx_byte1", rd, 32'h5A);
        cpu_read(1'b0, rd); check("rx_empty_status", rd, 32'h0);

        // RX overflow, sticky flag clear, in-order readout
        for (int i = 0; i < 17; i++) rx_byte(8'h30 + 8'(i));
        cpu_read(1'b0, rd); check("ovf_status", rd, 32'h5);
        cpu_write(1'b0, 32'h4);
        cpu_read(1'b0, rd); check("ovf_cleared", rd, 32'h1);
        for (int i = 0; i < 16; i++) begin
            cpu_read(1'b1, rd);
            check("rx_ovf_order", rd, 32'h30 + i);
        end
        cpu_read(1'b1, rd); check("rx_empty_read", rd, 32'h0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 5; i++) cpu_write(1'b1, 32'h1C0 + i);
        for (int i = 0; i < 3; i++) rx_byte(8'hE0 + 8'(i));
        cpu_read(1'b0, rd); check("pre_reset_status", rd, 32'h1);
        tx_ready = 1'b1;
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_rddata", bus_rddata, 32'h0);
        tx_q.delete(); rx_q.delete(); m_ovf = 1'b0; m_rd = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        cpu_read(1'b0, rd); check("post_reset_status", rd, 32'h0);
        cpu_read(1'b1, rd); check("post_reset_data", rd, 32'h0);
        tx_ready = 1'b0;
        cpu_write(1'b1, 32'h1AB);
        check("post_reset_tx", {23'b0, tx_data}, 32'h1AB);

        // Randomized traffic with phases of varying congestion
        for (int i = 0; i < 4000; i++) begin
            int unsigned ph;
            ph = i / 1000;
            bus_addr   = 1'($urandom_range(0, 1));
            bus_wrdata = $urandom;
            bus_wren   = ($urandom_range(0, 3) == 0);
            bus_rden   = ($urandom_range(0, 3) == 0);
            rx_data    = 8'($urandom);
            rx_valid   = (ph == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            tx_ready   = (ph == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            tick();
        end
        bus_wren = 1'b0; bus_rden = 1'b0; rx_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/esp_cmd_port.md
ESP_CMD_PORT -- requirements
Module: esp_cmd_port

Interface
REQ-001 Parameter: DEPTH_LOG2, 4, log2 of TX and RX FIFO depth; depth is 16 entries each.
REQ-002 clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 bus_addr  input  1  register select: 0 = STATUS, 1 = DATA.
REQ-005 bus_wrdata  input  32  CPU write data.
REQ-006 bus_wren  input  1  one-cycle CPU write strobe.
REQ-007 bus_rden  input  1  one-cycle CPU read strobe.
REQ-008 bus_rddata  output  32  registered CPU read data.
REQ-009 tx_data  output  9  byte to the ESP link; bit 8 = start-of-command flag.
REQ-010 tx_valid  output  1  tx_data holds a valid entry.
REQ-011 tx_ready  input  1  link accepts tx_data this cycle.
REQ-012 rx_data  input  8  byte from the ESP link.
REQ-013 rx_valid  input  1  rx_data is valid this cycle; always accepted, no back-pressure.

Function
REQ-014 Block is the memory-mapped responder for the CPU's ESP command protocol: CPU polls STATUS, writes command/argument bytes to DATA, reads response bytes from DATA.
REQ-015 STATUS read value: bit0 = RX FIFO not empty; bit1 = TX FIFO full (busy); bit2 = sticky RX overflow; bits 31:3 = 0.
REQ-016 DATA read: bits 7:0 = RX FIFO head, bits 31:8 = 0; entry popped in the same cycle; empty FIFO returns 0 with no pop and no pointer change.
REQ-017 bus_rddata updates on the clock edge following bus_rden (1-cycle latency) and holds its value until the next read.
REQ-018 DATA write: pushes bus_wrdata[8:0] into TX FIFO when not full; write while full is silently dropped; bits 31:9 ignored.
REQ-019 STATUS write: writing 1 to bit2 clears the overflow flag; all other bits ignored.
REQ-020 TX side: tx_valid = TX FIFO not empty, tx_data = head entry (first-word fall-through); head popped on the cycle where tx_valid and tx_ready are both high.
REQ-021 RX side: byte pushed on each rx_valid cycle; if FIFO full, byte dropped and overflow flag set.
REQ-022 Overflow set and CPU clear in the same cycle: set wins.
REQ-023 Simultaneous push and pop on one FIFO: both take effect; occupancy unchanged; legal when full (TX: pop frees the slot, so the push is accepted) and when empty (RX: the read returns 0 and the incoming byte is stored).
REQ-024 Each FIFO uses DEPTH_LOG2+1-bit read/write pointers; pointers wrap modulo 2^(DEPTH_LOG2+1); full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
REQ-025 STATUS bit0/bit1 reflect the FIFO state before the edge on which the read is sampled (no same-cycle bypass).
REQ-026 Data ordering is strict FIFO in both directions; no reordering and no duplication.

Reset
REQ-027 On reset assertion, immediately: all FIFO pointers = 0, overflow = 0, bus_rddata = 0, tx_valid = 0.
REQ-028 Reset during a transfer discards all queued bytes in both FIFOs; after reset releases, the first tx_valid occurs only after a new DATA write.
REQ-029 FIFO storage arrays need no reset; their contents are never visible while the FIFO is empty.

Verification
REQ-030 Reset, then read STATUS -> 0x00000000; read DATA -> 0x00000000.
REQ-031 With tx_ready=0, write DATA 0x110 then 0x000 -> tx_valid=1, tx_data=0x110; raise tx_ready for 2 cycles -> 0x110 then 0x000, then tx_valid=0.
REQ-032 With tx_ready=0, write 17 bytes 0x00..0x10 -> STATUS bit1=1 after the 16th; 17th dropped; drain -> exactly 0x00..0x0F.
REQ-033 Drive rx bytes 0xA5, 0x5A -> STATUS=0x1; two DATA reads -> 0xA5, 0x5A; STATUS then = 0x0.
REQ-034 Drive 17 rx bytes -> STATUS=0x5; write STATUS 0x4 -> bit2 clears; 16 reads return the first 16 bytes in order.
REQ-035 Assert reset mid-drain with 5 TX and 3 RX entries queued -> tx_valid=0 and STATUS=0 immediately, without waiting for a clock edge.
